// File: rtl/stopwatch_core.sv
// BCD minutes/seconds stopwatch that counts a divided 1 Hz tick in the clk_in domain.
// It has synchronised edge detection, a run/pause/idle FSM and a selectable 7-segment digit decode.
`timescale 1ns/1ps
module stopwatch_core #(
  parameter int SYNC_STAGES    = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic [1:0] digit_sel,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       rollover,
  output logic [6:0] seg
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  // Edges stay masked until an input held high through reset has reached the history flop.
  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] tick_sync_p0, ss_sync_p0, clr_sync_p0;
  logic                   tick_hist_p1, ss_hist_p1, clr_hist_p1;
  logic [2:0]             warm_cnt;
  logic                   edges_ok, tick_edge, ss_edge, clr_edge, count_en;
  state_t                 state_q, state_d;
  logic [3:0]             so_d, st_d, mo_d, mt_d;
  logic                   wrap_d;
  logic [3:0]             sel_digit;
  logic [6:0]             seg_raw;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Stage p0: synchronisers; stage p1: history flops for edge detection
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tick_sync_p0 <= '0;
      ss_sync_p0   <= '0;
      clr_sync_p0  <= '0;
      tick_hist_p1 <= 1'b0;
      ss_hist_p1   <= 1'b0;
      clr_hist_p1  <= 1'b0;
      warm_cnt     <= 3'd0;
    end else begin
      tick_sync_p0 <= {tick_sync_p0[SYNC_STAGES-2:0], tick_in};
      ss_sync_p0   <= {ss_sync_p0[SYNC_STAGES-2:0], btn_start_stop};
      clr_sync_p0  <= {clr_sync_p0[SYNC_STAGES-2:0], btn_clear};
      tick_hist_p1 <= tick_sync_p0[SYNC_STAGES-1];
      ss_hist_p1   <= ss_sync_p0[SYNC_STAGES-1];
      clr_hist_p1  <= clr_sync_p0[SYNC_STAGES-1];
      if (warm_cnt != WARM_DONE) warm_cnt <= warm_cnt + 3'd1;
    end
  end

  assign edges_ok  = (warm_cnt == WARM_DONE);
  assign tick_edge = tick_sync_p0[SYNC_STAGES-1] & ~tick_hist_p1 & edges_ok;
  assign ss_edge   = ss_sync_p0[SYNC_STAGES-1] & ~ss_hist_p1 & edges_ok;
  assign clr_edge  = clr_sync_p0[SYNC_STAGES-1] & ~clr_hist_p1 & edges_ok;
  assign count_en  = tick_edge & (state_q == RUN) & ~clr_edge;

  always_comb begin
    state_d = state_q;
    if (clr_edge) begin
      state_d = IDLE;
    end else if (ss_edge) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    so_d   = sec_ones;
    st_d   = sec_tens;
    mo_d   = min_ones;
    mt_d   = min_tens;
    wrap_d = 1'b0;
    if (clr_edge) begin
      so_d = 4'd0;
      st_d = 4'd0;
      mo_d = 4'd0;
      mt_d = 4'd0;
    end else if (count_en) begin
      if (sec_ones != 4'd9) begin
        so_d = sec_ones + 4'd1;
      end else begin
        so_d = 4'd0;
        if (sec_tens != 4'd5) begin
          st_d = sec_tens + 4'd1;
        end else begin
          st_d = 4'd0;
          if (min_ones != 4'd9) begin
            mo_d = min_ones + 4'd1;
          end else begin
            mo_d = 4'd0;
            if (min_tens != 4'd5) begin
              mt_d = min_tens + 4'd1;
            end else begin
              mt_d   = 4'd0;
              wrap_d = 1'b1;
            end
          end
        end
      end
    end
  end

  // Stage p2: state, count and status registers all update on the same edge
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
      running  <= 1'b0;
      rollover <= 1'b0;
    end else begin
      state_q  <= state_d;
      sec_ones <= so_d;
      sec_tens <= st_d;
      min_ones <= mo_d;
      min_tens <= mt_d;
      running  <= (state_d == RUN);
      rollover <= wrap_d;
    end
  end

  always_comb begin
    case (digit_sel)
      2'd0:    sel_digit = sec_ones;
      2'd1:    sel_digit = sec_tens;
      2'd2:    sel_digit = min_ones;
      default: sel_digit = min_tens;
    endcase
    seg_raw = seg7(sel_digit);
    seg     = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Randomised scoreboard bench for stopwatch_core: a seconds-count reference model queues the
// expected outputs per input event and a negedge monitor compares them in the cycle they are due.
`timescale 1ns/1ps
module tb_stopwatch_core;
  localparam int S = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0, btn_start_stop = 1'b0, btn_clear = 1'b0;
  logic [1:0] digit_sel = 2'd0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, rollover;
  logic [6:0] seg;
  logic [3:0] al_so, al_st, al_mo, al_mt;
  logic       al_running, al_rollover;
  logic [6:0] al_seg;

  stopwatch_core #(.SYNC_STAGES(S), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in), .btn_start_stop(btn_start_stop),
    .btn_clear(btn_clear), .digit_sel(digit_sel), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens), .running(running), .rollover(rollover), .seg(seg));

  stopwatch_core #(.SYNC_STAGES(S), .SEG_ACTIVE_LOW(1'b1)) dut_al (
    .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in), .btn_start_stop(btn_start_stop),
    .btn_clear(btn_clear), .digit_sel(digit_sel), .sec_ones(al_so), .sec_tens(al_st),
    .min_ones(al_mo), .min_tens(al_mt), .running(al_running), .rollover(al_rollover), .seg(al_seg));

  always #5 clk_in = ~clk_in;

  typedef struct {
    int due;
    int secs;
    int mode;
    bit roll;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   passes = 0, checks = 0;
  bit   mon_en = 1'b0;
  int   m_secs = 0, m_mode = M_IDLE;
  int   cur_secs = 0, cur_mode = M_IDLE;
  bit   cur_roll = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic int dig(input int secs, input int sel);
    case (sel)
      0: return secs % 10;
      1: return (secs % 60) / 10;
      2: return (secs / 60) % 10;
      default: return secs / 600;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
                  name, act, act, req, req, cyc);
  endtask

  // Monitor: pop the expectation due this cycle, then compare every output against the model.
  always @(negedge clk_in) begin
    #1;
    if (mon_en) begin
      logic [6:0] inv;
      cur_roll = 1'b0;
      if (q.size() > 0 && q[0].due < cyc) begin
        check("sb_missed_due", cyc, q[0].due);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        cur_secs = e.secs;
        cur_mode = e.mode;
        cur_roll = e.roll;
      end
      check("sec_ones", sec_ones, dig(cur_secs, 0));
      check("sec_tens", sec_tens, dig(cur_secs, 1));
      check("min_ones", min_ones, dig(cur_secs, 2));
      check("min_tens", min_tens, dig(cur_secs, 3));
      check("running", running, int'(cur_mode == M_RUN));
      check("rollover", rollover, int'(cur_roll));
      check("seg", seg, pat(dig(cur_secs, int'(digit_sel))));
      inv = ~pat(dig(cur_secs, int'(digit_sel)));
      check("seg_active_low", al_seg, inv);
      check("al_status", {al_mt, al_mo, al_st, al_so, al_running, al_rollover},
            {min_tens, min_ones, sec_tens, sec_ones, running, rollover});
    end
  end

  task automatic issue(input bit st, input bit cl, input bit tk, input int hi, input int lo);
    exp_t x;
    bit roll;
    @(negedge clk_in);
    btn_start_stop = st;
    btn_clear      = cl;
    tick_in        = tk;
    roll = 1'b0;
    if (cl) begin
      m_secs = 0;
      m_mode = M_IDLE;
    end else begin
      if (tk && m_mode == M_RUN) begin
        m_secs++;
        if (m_secs == 3600) begin
          m_secs = 0;
          roll   = 1'b1;
        end
      end
      if (st) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
    end
    x.due = cyc + 1 + S; x.secs = m_secs; x.mode = m_mode; x.roll = roll;
    q.push_back(x);
    repeat (hi) begin @(negedge clk_in); digit_sel = 2'($urandom_range(0, 3)); end
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    tick_in        = 1'b0;
    repeat (lo) begin @(negedge clk_in); digit_sel = 2'($urandom_range(0, 3)); end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 1'b1, S + 1, S + 1);
  endtask

  task automatic press_start();
    issue(1'b1, 1'b0, 1'b0, S + 1, S + 1);
  endtask

  task automatic press_clear();
    issue(1'b0, 1'b1, 1'b0, S + 1, S + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] dec_exp [4];
    logic [6:0] inv;
    dec_exp[0] = 7'b1111111;
    dec_exp[1] = 7'b1100110;
    dec_exp[2] = 7'b1101111;
    dec_exp[3] = 7'b1101101;

    // Reset with start held high: no edge may appear after release.
    btn_start_stop = 1'b1;
    repeat (3) @(negedge clk_in);
    #2;
    check("rst_digits", {min_tens, min_ones, sec_tens, sec_ones}, 0);
    check("rst_running", running, 0);
    check("rst_rollover", rollover, 0);
    check("rst_seg", seg, 7'b0111111);
    check("rst_seg_al", al_seg, 7'b1000000);
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (8) @(negedge clk_in);
    #2;
    check("held_high_no_edge_running", running, 0);
    btn_start_stop = 1'b0;
    repeat (4) @(negedge clk_in);
    #2;
    check("held_high_no_edge_after_fall", running, 0);
    mon_en = 1'b1;

    // Start and five ticks
    press_start();
    ticks(5);
    #2;
    check("five_ticks_sec_ones", sec_ones, 5);

    // Pause behaviour
    press_clear(); press_start(); ticks(3); press_start(); ticks(4);
    #2;
    check("pause_holds", sec_ones, 3);
    check("pause_not_running", running, 0);
    press_start(); ticks(1);
    #2;
    check("resume_counts", sec_ones, 4);

    // Simultaneous events
    press_clear(); press_start(); ticks(7);
    issue(1'b0, 1'b1, 1'b1, S + 1, S + 1);
    #2;
    check("clear_beats_tick", {min_tens, min_ones, sec_tens, sec_ones}, 0);
    press_start(); ticks(7);
    issue(1'b1, 1'b0, 1'b1, S + 1, S + 1);
    #2;
    check("start_tick_in_run", sec_ones, 8);
    check("start_tick_pauses", running, 0);

    // Randomised event mix
    for (int i = 0; i < 120; i++) begin
      int r, hi, lo;
      r  = $urandom_range(0, 99);
      hi = $urandom_range(S + 1, S + 3);
      lo = $urandom_range(S + 1, S + 3);
      if (r < 65)      issue(1'b0, 1'b0, 1'b1, hi, lo);
      else if (r < 77) issue(1'b1, 1'b0, 1'b0, hi, lo);
      else if (r < 82) issue(1'b0, 1'b1, 1'b0, hi, lo);
      else if (r < 90) issue(1'b1, 1'b0, 1'b1, hi, lo);
      else if (r < 95) issue(1'b0, 1'b1, 1'b1, hi, lo);
      else             issue(1'b1, 1'b1, 1'b1, hi, lo);
    end

    // Carry chain, decode at 59:48, and rollover
    press_clear(); press_start(); ticks(59);
    #2;
    check("at_00_59", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0059);
    ticks(1);
    #2;
    check("carry_01_00", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0100);
    ticks(3528);
    press_start();
    for (int s = 0; s < 4; s++) begin
      @(negedge clk_in);
      digit_sel = 2'(s);
      #2;
      check("decode_59_48", seg, dec_exp[s]);
      inv = ~dec_exp[s];
      check("decode_59_48_al", al_seg, inv);
    end
    press_start();
    ticks(11);
    #2;
    check("at_59_59", {min_tens, min_ones, sec_tens, sec_ones}, 16'h5959);
    ticks(1);
    #2;
    check("wrap_00_00", {min_tens, min_ones, sec_tens, sec_ones}, 0);
    check("wrap_still_running", running, 1);

    // Reach 12:34 and assert reset between clock edges
    ticks(754);
    #2;
    check("at_12_34", {min_tens, min_ones, sec_tens, sec_ones}, 16'h1234);
    mon_en = 1'b0;
    q.delete();
    rst_n = 1'b0;
    #1;
    check("async_rst_digits", {min_tens, min_ones, sec_tens, sec_ones}, 0);
    check("async_rst_running", running, 0);
    digit_sel = 2'd3;
    #1;
    check("async_rst_seg", seg, 7'b0111111);
    check("async_rst_seg_al", al_seg, 7'b1000000);
    repeat (3) @(negedge clk_in);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
